pipelined_cpu: RTL and testbench
================================

# pipelined_cpu

Five-stage in-order RV32 integer pipeline (IF, ID, EX, MEM, WB) with on-chip instruction memory, data memory and register file. It is the top level of the processor. Inputs are only clock, reset and start; all results are visible in its internal register file and data memory. It resolves data hazards by forwarding and load-use stalling, and resolves control hazards by deciding branches in ID and flushing one instruction.

## Interface
- No parameters. IMEM depth is 256 words; DMEM is 32 bytes; the register file is 32 x 32 bits.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  run enable; the PC advances only while high.
- Required instance names: PC (register pc_o), Instruction_Memory (array memory[0:255] of 32-bit words), Data_Memory (array memory[0:31] of bytes), Registers (array register[0:31]), Control, HazardDetection (Stall_o, Flush_o), ID_EX, EX_MEM, MEM_WB.

## Operation
- ISA, decoded from opcode/funct3/funct7:
  - R-type 0110011: and (111), xor (100), sll (001), add (000), sub (000, funct7 0100000), mul (000, funct7 0000001; low 32 bits).
  - I-type 0010011: addi (000); srai (101, funct7 0100000, shamt = imm[4:0], arithmetic shift).
  - lw 0000011/010; sw 0100011/010; beq 1100011/000.
  - Any other encoding, including all-zero, is a NOP with no register or memory write.
- Immediates are sign-extended from 12 bits. The beq offset is {imm[12:1],0}.
- IF: instruction = IMEM[pc[9:2]]; the next PC is pc+4 unless a branch is taken or a stall is active.
- ID:
  - Register read, with write-through: a same-cycle WB write to the register being read is visible in the read data.
  - beq compares the two register-file values; taken target = ID-stage PC + offset.
  - A taken branch asserts Flush_o, which loads the target into the PC and turns the IF/ID instruction into a NOP.
  - There is no forwarding into the ID compare; program order must separate producers from a beq.
- Load-use hazard:
  - Condition: ID_EX.MemRead && ID_EX.rd != 0 && rd matches rs1 or rs2 of the ID instruction.
  - Response: Stall_o = 1; PC and IF/ID hold; ID/EX receives all-zero controls (bubble) for exactly one cycle.
- EX forwarding, with priority EX/MEM over MEM/WB:
  - Forward from EX/MEM when RegWrite && rd != 0 && rd == rs; otherwise from MEM/WB under the same test.
  - The source is the ALU result from EX/MEM, or the writeback mux output from MEM/WB.
  - The sw store data is the forwarded rs2.
- MEM:
  - lw reads 4 bytes little-endian at addr[4:0]; sw writes 4 bytes at the rising edge.
  - Addresses are word-aligned; unaligned or out-of-range accesses are undefined and need not be checked.
- WB: rd <- MemtoReg ? mem data : ALU result, when RegWrite && rd != 0. x0 always reads 0.

## Timing
- While rst_i = 0 at a rising edge:
  - PC = 0.
  - IF/ID, ID/EX, EX/MEM and MEM/WB contents, including all control bits, = 0.
  - Register file and memories are not cleared; the bench preloads them.
- start_i = 0 with rst_i = 1: the PC holds and the pipeline keeps clocking (IMEM[0] is refetched).
- Latency: an instruction fetched at cycle n writes back at the edge ending cycle n+4. A register read at cycle n+4 sees the value.
- Taken beq: the target is fetched on the cycle after ID, so there is exactly 1 flushed slot.
- Load-use: exactly 1 bubble.
- Stall and flush in the same cycle: the stall has priority; the branch re-evaluates next cycle with the same operands.

## Structure
- Shared package holds:
  - opcode, funct3 and funct7 constants;
  - the ALU control enum (AND, XOR, SLL, ADD, SUB, MUL, SRA);
  - the ALUOp encoding (00 add for lw/sw/addi-class, 01 sub for beq, 10 R-type, 11 I-type ALU);
  - the pipeline-register field widths.
- A single natural sub-module is pipe_reg: a synchronous active-low-reset register with enable/clear, instantiated per stage.
- Control, hazard detection and forwarding stay as small internal blocks.

## Test plan
- Reset then start: hold rst_i = 0 for 1 edge, with start_i = 1 after. Required: PC = 0 during reset, then 4, 8, … per cycle; all pipeline controls = 0 under reset.
- Forwarding: addi x1,x0,5; add x2,x1,x1; sub x3,x2,x1; mul x4,x2,x2. Required: x2 = 10, x3 = 5, x4 = 100, with no stall.
- Load-use: DMEM[0] = 5; lw x5,0(x0); add x6,x5,x5. Required: 1 stall cycle, x6 = 10, PC held for one cycle.
- Store/load: addi x7,x0,-3; sw x7,8(x0); lw x8,8(x0). Required: DMEM word 0x08 = 0xFFFFFFFD, x8 = -3.
- Branch: beq x0,x0,+8 followed by addi x9,x0,1 and then addi x10,x0,2. Required: 1 flush, x9 = 0, x10 = 2; beq x0,x1 not taken with x1 ≠ 0 gives 0 flushes.
- Shifts/logic: x1 = -16; srai x11,x1,2; sll x12,x2,x1low; and/xor checks. Required: x11 = -4; a write to x0 is ignored and x0 stays 0.

Source files
------------

// File: rtl/pipelined_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cpu_pkg
// Description : Shared RV32 subset constants: opcodes, funct fields, ALU
//               control enum, ALUOp encoding and the pipeline-register
//               layouts used by the five-stage core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRA = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_XOR = 3'd1,
        ALU_SLL = 3'd2,
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4,
        ALU_MUL = 3'd5,
        ALU_SRA = 3'd6
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } id_ex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] mem_data;
        logic [XLEN-1:0] alu_result;
        logic [4:0]      rd;
    } mem_wb_t;

    // ALUOp plus funct fields to the concrete ALU operation.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic [6:0] funct7);
        alu_ctrl_e res;
        res = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: res = ALU_SUB;
            ALUOP_R: begin
                if (funct3 == F3_AND)      res = ALU_AND;
                else if (funct3 == F3_XOR) res = ALU_XOR;
                else if (funct3 == F3_SLL) res = ALU_SLL;
                else if (funct7 == F7_ALT) res = ALU_SUB;
                else if (funct7 == F7_MUL) res = ALU_MUL;
                else                       res = ALU_ADD;
            end
            ALUOP_I: begin
                if (funct3 == F3_SRA) res = ALU_SRA;
                else                  res = ALU_ADD;
            end
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cpu_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Pipeline stage register with synchronous active-low reset,
//               synchronous clear (bubble/flush) and load enable (hold).
// Ports       : clk, rst_n, en, clr, d[WIDTH-1:0] -> q[WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    import pipelined_cpu_pkg::*;

    always_ff @(posedge clk) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_cpu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cpu
// Description : Five-stage in-order RV32 subset core with on-chip IMEM
//               (256 words), DMEM (32 bytes) and 32x32 register file.
//               EX forwarding, one-bubble load-use stall, beq resolved in ID
//               with a single flushed slot.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-low reset
//               start_i - run enable; PC advances only while high
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cpu (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    import pipelined_cpu_pkg::*;

    logic [XLEN-1:0] pc, instr_if, branch_target, id_imm, rs1_data, rs2_data;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result, mem_rdata, wb_data;
    logic            stall, flush, id_branch, wb_we;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           id_ctrl;
    if_id_t          if_id_d, if_id;
    id_ex_t          id_ex_d, id_ex;
    ex_mem_t         ex_mem_d, ex_mem;
    mem_wb_t         mem_wb_d, mem_wb;

    // ---------------------------------------------------------------- IF
    if (1) begin : PC
        logic [XLEN-1:0] pc_o;
        // Stall outranks the branch redirect; start only gates sequential advance.
        always_ff @(posedge clk_i) begin
            if (!rst_i)             pc_o <= '0;
            else if (!stall) begin
                if (flush)          pc_o <= branch_target;
                else if (start_i)   pc_o <= pc_o + 32'd4;
            end
        end
        assign pc = pc_o;
    end

    if (1) begin : Instruction_Memory
        logic [XLEN-1:0] memory [0:255];
        assign instr_if = memory[pc[9:2]];
    end

    assign if_id_d = '{pc: pc, instr: instr_if};

    pipe_reg #(.WIDTH($bits(if_id_t))) IF_ID (
        .clk(clk_i), .rst_n(rst_i), .en(!stall), .clr(flush), .d(if_id_d), .q(if_id)
    );

    // ---------------------------------------------------------------- ID
    assign opcode = if_id.instr[6:0];
    assign rd     = if_id.instr[11:7];
    assign funct3 = if_id.instr[14:12];
    assign rs1    = if_id.instr[19:15];
    assign rs2    = if_id.instr[24:20];
    assign funct7 = if_id.instr[31:25];

    if (1) begin : Control
        logic [1:0] alu_op;
        always_comb begin
            id_ctrl   = '0;
            id_branch = 1'b0;
            alu_op    = ALUOP_ADD;
            case (opcode)
                OP_R: begin
                    alu_op = ALUOP_R;
                    case ({funct7, funct3})
                        {F7_BASE, F3_AND}, {F7_BASE, F3_XOR}, {F7_BASE, F3_SLL},
                        {F7_BASE, F3_ADD}, {F7_ALT, F3_ADD}, {F7_MUL, F3_ADD}:
                            id_ctrl.reg_write = 1'b1;
                        default: ;
                    endcase
                end
                OP_I: begin
                    alu_op           = ALUOP_I;
                    id_ctrl.alu_src  = 1'b1;
                    id_ctrl.reg_write = (funct3 == F3_ADD) ||
                                        (funct3 == F3_SRA && funct7 == F7_ALT);
                end
                OP_LW: if (funct3 == F3_LSW) begin
                    id_ctrl.reg_write  = 1'b1;
                    id_ctrl.mem_to_reg = 1'b1;
                    id_ctrl.mem_read   = 1'b1;
                    id_ctrl.alu_src    = 1'b1;
                end
                OP_SW: if (funct3 == F3_LSW) begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.alu_src   = 1'b1;
                end
                OP_BEQ: if (funct3 == F3_BEQ) begin
                    id_branch = 1'b1;
                    alu_op    = ALUOP_SUB;
                end
                default: ;
            endcase
            id_ctrl.alu_ctrl = alu_decode(alu_op, funct3, funct7);
        end
    end

    always_comb begin
        case (opcode)
            OP_SW:   id_imm = {{20{if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
            OP_BEQ:  id_imm = {{19{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                               if_id.instr[30:25], if_id.instr[11:8], 1'b0};
            default: id_imm = {{20{if_id.instr[31]}}, if_id.instr[31:20]};
        endcase
    end

    assign branch_target = if_id.pc + id_imm;
    assign wb_we         = mem_wb.reg_write && (mem_wb.rd != 5'd0);

    if (1) begin : Registers
        logic [XLEN-1:0] register [0:31];
        always_ff @(posedge clk_i) begin
            if (wb_we) register[mem_wb.rd] <= wb_data;
        end
        // Write-through lets an instruction in ID see the same-cycle writeback.
        always_comb begin
            rs1_data = register[rs1];
            rs2_data = register[rs2];
            if (rs1 == 5'd0)                       rs1_data = '0;
            else if (wb_we && mem_wb.rd == rs1)    rs1_data = wb_data;
            if (rs2 == 5'd0)                       rs2_data = '0;
            else if (wb_we && mem_wb.rd == rs2)    rs2_data = wb_data;
        end
    end

    if (1) begin : HazardDetection
        logic Stall_o, Flush_o;
        assign Stall_o = id_ex.ctrl.mem_read && (id_ex.rd != 5'd0) &&
                         (id_ex.rd == rs1 || id_ex.rd == rs2);
        assign Flush_o = id_branch && (rs1_data == rs2_data) && !Stall_o;
        assign stall   = Stall_o;
        assign flush   = Flush_o;
    end

    assign id_ex_d = '{ctrl: id_ctrl, rs1_data: rs1_data, rs2_data: rs2_data,
                       imm: id_imm, rs1: rs1, rs2: rs2, rd: rd};

    // A stall turns the ID/EX load into a bubble.
    pipe_reg #(.WIDTH($bits(id_ex_t))) ID_EX (
        .clk(clk_i), .rst_n(rst_i), .en(1'b1), .clr(stall), .d(id_ex_d), .q(id_ex)
    );

    // ---------------------------------------------------------------- EX
    always_comb begin
        fwd_a = id_ex.rs1_data;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
            fwd_a = ex_mem.alu_result;
        else if (wb_we && mem_wb.rd == id_ex.rs1)
            fwd_a = wb_data;
        fwd_b = id_ex.rs2_data;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
            fwd_b = ex_mem.alu_result;
        else if (wb_we && mem_wb.rd == id_ex.rs2)
            fwd_b = wb_data;
    end

    assign op_b = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;

    always_comb begin
        case (id_ex.ctrl.alu_ctrl)
            ALU_AND: alu_result = fwd_a & op_b;
            ALU_XOR: alu_result = fwd_a ^ op_b;
            ALU_SLL: alu_result = fwd_a << op_b[4:0];
            ALU_SUB: alu_result = fwd_a - op_b;
            ALU_MUL: alu_result = fwd_a * op_b;
            ALU_SRA: alu_result = $signed(fwd_a) >>> op_b[4:0];
            default: alu_result = fwd_a + op_b;
        endcase
    end

    assign ex_mem_d = '{reg_write: id_ex.ctrl.reg_write, mem_to_reg: id_ex.ctrl.mem_to_reg,
                        mem_write: id_ex.ctrl.mem_write, alu_result: alu_result,
                        store_data: fwd_b, rd: id_ex.rd};

    pipe_reg #(.WIDTH($bits(ex_mem_t))) EX_MEM (
        .clk(clk_i), .rst_n(rst_i), .en(1'b1), .clr(1'b0), .d(ex_mem_d), .q(ex_mem)
    );

    // ---------------------------------------------------------------- MEM
    if (1) begin : Data_Memory
        logic [7:0] memory [0:31];
        logic [4:0] addr;
        assign addr = ex_mem.alu_result[4:0];
        always_ff @(posedge clk_i) begin
            if (ex_mem.mem_write) begin
                memory[addr]         <= ex_mem.store_data[7:0];
                memory[addr + 5'd1]  <= ex_mem.store_data[15:8];
                memory[addr + 5'd2]  <= ex_mem.store_data[23:16];
                memory[addr + 5'd3]  <= ex_mem.store_data[31:24];
            end
        end
        assign mem_rdata = {memory[addr + 5'd3], memory[addr + 5'd2],
                            memory[addr + 5'd1], memory[addr]};
    end

    assign mem_wb_d = '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg,
                        mem_data: mem_rdata, alu_result: ex_mem.alu_result, rd: ex_mem.rd};

    pipe_reg #(.WIDTH($bits(mem_wb_t))) MEM_WB (
        .clk(clk_i), .rst_n(rst_i), .en(1'b1), .clr(1'b0), .d(mem_wb_d), .q(mem_wb)
    );

    // ---------------------------------------------------------------- WB
    assign wb_data = mem_wb.mem_to_reg ? mem_wb.mem_data : mem_wb.alu_result;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cpu
// Description : Directed self-checking bench for pipelined_cpu. Loads small
//               programs into IMEM, runs a fixed number of cycles and checks
//               register file, data memory, PC and hazard activity against
//               hand-computed values.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cpu;
    import pipelined_cpu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int          n_stall;
    int          n_flush;
    logic [31:0] pc_end;

    pipelined_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2,
                                          input int rs1, input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                          input logic [2:0] f3, input int rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), F3_LSW, v[4:0], OP_SW};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1);
        logic [31:0] v;
        v = off;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), F3_BEQ, v[4:1], v[11], OP_BEQ};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_chk(input string tag, input int r, input logic [31:0] exp);
        check(tag, dut.Registers.register[r], exp);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.Instruction_Memory.memory[idx] = w;
    endtask

    // One reset edge, then `cycles` running edges; counts stall/flush cycles.
    task automatic run(input int cycles);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        n_stall = 0; n_flush = 0;
        for (int i = 0; i < cycles; i++) begin
            n_stall += int'(dut.HazardDetection.Stall_o);
            n_flush += int'(dut.HazardDetection.Flush_o);
            @(posedge clk); #1;
        end
        pc_end = dut.PC.pc_o;
        start = 1'b0;
    endtask

    initial begin
        // ---------------- reset / PC sequencing (forwarding program loaded)
        clear_imem();
        put(0,  enc_i(5, 0, F3_ADD, 1, OP_I));              // addi x1,x0,5
        put(1,  enc_r(F7_BASE, 1, 1, F3_ADD, 2));           // add  x2,x1,x1
        put(2,  enc_r(F7_ALT, 1, 2, F3_ADD, 3));            // sub  x3,x2,x1
        put(3,  enc_r(F7_MUL, 2, 2, F3_ADD, 4));            // mul  x4,x2,x2
        put(4,  enc_i(1, 0, F3_ADD, 15, OP_I));             // addi x15,x0,1
        put(5,  enc_i(2, 0, F3_ADD, 15, OP_I));             // addi x15,x0,2
        put(6,  enc_r(F7_BASE, 15, 15, F3_ADD, 16));        // add  x16,x15,x15
        put(7,  enc_i(7, 0, F3_ADD, 17, OP_I));             // addi x17,x0,7
        put(10, enc_r(F7_BASE, 0, 17, F3_ADD, 18));         // add  x18,x17,x0
        run(4);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_pc",     dut.PC.pc_o, 32'd0);
        check("rst_if_id",  {31'd0, |dut.IF_ID.q},  32'd0);
        check("rst_id_ex",  {31'd0, |dut.ID_EX.q},  32'd0);
        check("rst_ex_mem", {31'd0, |dut.EX_MEM.q}, 32'd0);
        check("rst_mem_wb", {31'd0, |dut.MEM_WB.q}, 32'd0);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1; check("pc_step1", dut.PC.pc_o, 32'd4);
        @(posedge clk); #1; check("pc_step2", dut.PC.pc_o, 32'd8);
        @(posedge clk); #1; check("pc_step3", dut.PC.pc_o, 32'd12);
        start = 1'b0;
        @(posedge clk); #1; check("pc_hold_nostart", dut.PC.pc_o, 32'd12);

        // ---------------- forwarding, priority, write-through
        run(20);
        reg_chk("fwd_x1", 1, 32'd5);
        reg_chk("fwd_x2", 2, 32'd10);
        reg_chk("fwd_x3", 3, 32'd5);
        reg_chk("fwd_x4", 4, 32'd100);
        reg_chk("fwd_prio_x16", 16, 32'd4);
        reg_chk("wthru_x18", 18, 32'd7);
        check("fwd_stalls", n_stall, 32'd0);
        check("fwd_pc_end", pc_end, 32'd80);

        // ---------------- load-use
        clear_imem();
        dut.Data_Memory.memory[0] = 8'h05;
        dut.Data_Memory.memory[1] = 8'h00;
        dut.Data_Memory.memory[2] = 8'h00;
        dut.Data_Memory.memory[3] = 8'h00;
        put(0, enc_i(0, 0, F3_LSW, 5, OP_LW));              // lw  x5,0(x0)
        put(1, enc_r(F7_BASE, 5, 5, F3_ADD, 6));            // add x6,x5,x5
        run(12);
        check("lu_stalls", n_stall, 32'd1);
        reg_chk("lu_x5", 5, 32'd5);
        reg_chk("lu_x6", 6, 32'd10);
        check("lu_pc_end", pc_end, 32'd44);

        // ---------------- store then load
        clear_imem();
        for (int i = 8; i < 12; i++) dut.Data_Memory.memory[i] = 8'h00;
        put(0, enc_i(-3, 0, F3_ADD, 7, OP_I));              // addi x7,x0,-3
        put(1, enc_s(8, 7, 0));                             // sw   x7,8(x0)
        put(2, enc_i(8, 0, F3_LSW, 8, OP_LW));              // lw   x8,8(x0)
        run(12);
        check("st_word8", {dut.Data_Memory.memory[11], dut.Data_Memory.memory[10],
                           dut.Data_Memory.memory[9],  dut.Data_Memory.memory[8]},
              32'hFFFF_FFFD);
        reg_chk("ld_x8", 8, 32'hFFFF_FFFD);
        check("st_stalls", n_stall, 32'd0);

        // ---------------- branches
        clear_imem();
        put(0, enc_i(0, 0, F3_ADD, 9, OP_I));               // addi x9,x0,0
        put(1, enc_i(3, 0, F3_ADD, 1, OP_I));               // addi x1,x0,3
        put(4, enc_b(8, 1, 0));                             // beq x0,x1,+8 (not taken)
        put(5, enc_b(8, 0, 0));                             // beq x0,x0,+8 (taken)
        put(6, enc_i(1, 0, F3_ADD, 9, OP_I));               // addi x9,x0,1 (skipped)
        put(7, enc_i(2, 0, F3_ADD, 10, OP_I));              // addi x10,x0,2
        run(16);
        check("br_flushes", n_flush, 32'd1);
        reg_chk("br_x9", 9, 32'd0);
        reg_chk("br_x10", 10, 32'd2);

        // ---------------- stall and branch in the same cycle
        clear_imem();
        put(0, enc_i(0, 0, F3_ADD, 20, OP_I));              // addi x20,x0,0
        put(1, enc_i(0, 0, F3_LSW, 19, OP_LW));             // lw   x19,0(x0)
        put(2, enc_b(8, 19, 19));                           // beq  x19,x19,+8
        put(3, enc_i(1, 0, F3_ADD, 20, OP_I));              // addi x20,x0,1 (skipped)
        put(4, enc_i(4, 0, F3_ADD, 21, OP_I));              // addi x21,x0,4
        run(14);
        check("sf_stalls", n_stall, 32'd1);
        check("sf_flushes", n_flush, 32'd1);
        reg_chk("sf_x20", 20, 32'd0);
        reg_chk("sf_x21", 21, 32'd4);

        // ---------------- shifts, logic, x0, unsupported encoding
        clear_imem();
        put(0,  enc_i(-16, 0, F3_ADD, 1, OP_I));            // addi x1,x0,-16
        put(1,  enc_i(123, 0, F3_ADD, 2, OP_I));            // addi x2,x0,123
        put(2,  enc_i(9, 0, F3_ADD, 23, OP_I));             // addi x23,x0,9
        put(3,  enc_i(6, 0, F3_ADD, 24, OP_I));             // addi x24,x0,6
        put(4,  enc_i(32'h402, 1, F3_SRA, 11, OP_I));       // srai x11,x1,2
        put(5,  enc_r(F7_BASE, 1, 2, F3_SLL, 12));          // sll  x12,x2,x1
        put(6,  enc_r(F7_BASE, 2, 1, F3_AND, 13));          // and  x13,x1,x2
        put(7,  enc_r(F7_BASE, 2, 1, F3_XOR, 14));          // xor  x14,x1,x2
        put(8,  enc_i(5, 0, F3_ADD, 0, OP_I));              // addi x0,x0,5
        put(9,  enc_r(F7_BASE, 0, 0, F3_ADD, 23));          // add  x23,x0,x0
        put(10, enc_r(F7_BASE, 2, 1, 3'b010, 24));          // slt  -> no-op
        run(25);
        reg_chk("srai_x11", 11, 32'hFFFF_FFFC);
        reg_chk("sll_x12",  12, 32'h007B_0000);
        reg_chk("and_x13",  13, 32'h0000_0070);
        reg_chk("xor_x14",  14, 32'hFFFF_FF8B);
        reg_chk("x0_fwd_x23", 23, 32'd0);
        reg_chk("nop_x24", 24, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
